shadow_register_bank: RTL

SHADOW_REGISTER_BANK -- requirements
Module: shadow_register_bank

---
 rtl/shadow_register_bank_pkg.sv | 23 ++
 rtl/shadow_register_bank_bank_reg_cell.sv | 41 ++++
 rtl/shadow_register_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/shadow_register_bank_pkg.sv
// Shared register-controller defaults plus the types used by the shadow register bank.
// rcntlr_defines carries only the two bank-wide defaults.
package rcntlr_defines;
    localparam int DATA_WIDTH      = 8;
    localparam int LOG_N_REGISTERS = 5;
endpackage

package shadow_register_bank_pkg;
    localparam int BYTE_W          = 8;
    localparam int DEF_DATA_WIDTH  = rcntlr_defines::DATA_WIDTH;
    localparam int DEF_N_REGS      = 1 << rcntlr_defines::LOG_N_REGISTERS;

    // Single-cycle status pulses, registered one edge after the request.
    typedef struct packed {
        logic rd_valid;
        logic err;
        logic commit_done;
    } pulse_t;

    function automatic logic any_strobe(input logic [31:0] strb);
        return |strb;
    endfunction
endpackage

// File: rtl/shadow_register_bank_bank_reg_cell.sv
// One register of the bank: a byte-strobed shadow copy and an active copy
// that loads the (pre-write) shadow value on commit.
module bank_reg_cell
    import shadow_register_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    parameter bit                    READ_ONLY  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       commit,
    output logic [DATA_WIDTH-1:0]      shadow,
    output logic [DATA_WIDTH-1:0]      active
);

    localparam int N_BYTES = DATA_WIDTH / BYTE_W;

    // Non-blocking update: commit captures shadow as it was before this edge's write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= RST_VAL;
            active <= RST_VAL;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (we && !READ_ONLY) begin
                for (int b = 0; b < N_BYTES; b++) begin
                    if (wstrb[b]) begin
                        shadow[b*BYTE_W +: BYTE_W] <= data_in[b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/shadow_register_bank.sv
// Bank of shadow/active register pairs: bus writes land in shadow, commit
// copies every shadow to active at once, chip_out exposes the active copies.
module shadow_register_bank
    import shadow_register_bank_pkg::*;
#(
    parameter int                             DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                             N_REGS     = DEF_N_REGS,
    parameter int                             ADDR_W     = $clog2(N_REGS),
    parameter logic [N_REGS-1:0]              RO_MASK    = '0,
    parameter logic [N_REGS*DATA_WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr,
    input  logic                           rd,
    input  logic [ADDR_W-1:0]              address,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           commit,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           rd_valid,
    output logic                           err,
    output logic                           commit_done,
    output logic [N_REGS*DATA_WIDTH-1:0]   chip_out
);

    // Interface timing: requests are sampled at a rising edge and never stalled;
    // rd_valid, err and commit_done each pulse for exactly the cycle after that edge.

    logic [DATA_WIDTH-1:0] shadow_w [N_REGS];
    logic [DATA_WIDTH-1:0] active_w [N_REGS];
    logic [N_REGS-1:0]     cell_we;
    logic                  in_range;
    logic                  ro_hit;
    logic                  wr_err;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_sel;
    pulse_t                pulse_d;
    pulse_t                pulse_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    // Address decode by comparison so non-power-of-two banks never index out of bounds.
    always_comb begin
        in_range = 1'b0;
        ro_hit   = 1'b0;
        rd_sel   = '0;
        cell_we  = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (address == ADDR_W'(i)) begin
                in_range   = 1'b1;
                ro_hit     = RO_MASK[i];
                rd_sel     = shadow_w[i];
                cell_we[i] = wr & ~RO_MASK[i];
            end
        end
    end

    // A write with no strobes is a no-op and is never flagged.
    always_comb begin
        wr_err = wr & any_strobe(32'(wstrb)) & (~in_range | ro_hit);
        rd_err = rd & ~in_range;
        pulse_d.rd_valid    = rd;
        pulse_d.err         = wr_err | rd_err;
        pulse_d.commit_done = commit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_q    <= '0;
            data_out_q <= '0;
        end else begin
            pulse_q <= pulse_d;
            if (rd) begin
                data_out_q <= in_range ? rd_sel : '0;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REGS; g++) begin : g_cell
            bank_reg_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .RST_VAL    (RST_VAL[g*DATA_WIDTH +: DATA_WIDTH]),
                .READ_ONLY  (RO_MASK[g])
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .we      (cell_we[g]),
                .wstrb   (wstrb),
                .data_in (data_in),
                .commit  (commit),
                .shadow  (shadow_w[g]),
                .active  (active_w[g])
            );
            assign chip_out[g*DATA_WIDTH +: DATA_WIDTH] = active_w[g];
        end
    endgenerate

    assign data_out    = data_out_q;
    assign rd_valid    = pulse_q.rd_valid;
    assign err         = pulse_q.err;
    assign commit_done = pulse_q.commit_done;

endmodule
